// File: rtl/cam_capture_wr_pkg.sv
// Shared types and constants for the camera capture write path:
// FSM state encoding, RGB565->RGB111 bit picks, frame size.
package cam_capture_wr_pkg;

  localparam int IMG_W_DEF = 80;
  localparam int IMG_H_DEF = 60;
  localparam int FRAME_PIX = IMG_W_DEF * IMG_H_DEF;

  // MSB of each colour field: R5 and G6 live in the hi byte,
  // B5 in the lo byte of the RGB565 pair.
  localparam int R_MSB = 7;
  localparam int G_MSB = 2;
  localparam int B_MSB = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    BYTE1   = 2'd2,
    BYTE2   = 2'd3
  } state_t;

  function automatic int frame_pix(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/cam_capture_wr_if.sv
// Frame buffer write port bundle: addr_in, data_in, regwrite.
// master drives the port, slave (the buffer) receives it.
interface cam_capture_wr_if #(
  parameter int AW = 13,
  parameter int DW = 3
);
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;

  modport master (
    output addr_in,
    output data_in,
    output regwrite
  );

  modport slave (
    input addr_in,
    input data_in,
    input regwrite
  );
endinterface

// File: rtl/cam_capture_wr_rgb565_to_rgb111.sv
// Combinational packer: RGB565 byte pair -> RGB111 {R,G,B}.
// Ports: i_hi/i_lo camera bytes, o_rgb packed pixel.
module rgb565_to_rgb111
  import cam_capture_wr_pkg::*;
(
  input  logic [7:0] i_hi,
  input  logic [7:0] i_lo,
  output logic [2:0] o_rgb
);

  // Only the field MSBs survive the colour reduction.
  logic w_unused;
  assign w_unused = ^{i_hi, i_lo};

  assign o_rgb = {i_hi[R_MSB], i_hi[G_MSB], i_lo[B_MSB]};

endmodule

// File: rtl/cam_capture_wr.sv
// OV7670 RGB565 capture -> RGB111 frame buffer writer.
// Ports: clk/rst_n, cap_en, vsync/href/px_data, wr (buffer port), frame_done, overflow.
module cam_capture_wr
  import cam_capture_wr_pkg::*;
#(
  parameter int AW    = 13,
  parameter int DW    = 3,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cap_en,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] px_data,
  cam_capture_wr_if.master wr,
  output logic       frame_done,
  output logic       overflow
);

  localparam logic [AW-1:0] L_FRAME = AW'(frame_pix(IMG_W, IMG_H));

  state_t        r_state;
  state_t        w_state_n;
  logic          r_vs_q;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_n;
  logic [7:0]    r_hi;
  logic [7:0]    w_hi_n;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_n;
  logic [DW-1:0] r_data;
  logic [DW-1:0] w_data_n;
  logic          r_we;
  logic          w_we_n;
  logic          r_done;
  logic          w_done_n;
  logic          r_ovf;
  logic          w_ovf_n;

  logic          w_fall;
  logic          w_rise;
  logic          w_full;
  logic [2:0]    w_pix;

  assign w_fall = r_vs_q & ~vsync;
  assign w_rise = ~r_vs_q & vsync;
  assign w_full = (r_cnt == L_FRAME);

  rgb565_to_rgb111 u_pack (
    .i_hi  (r_hi),
    .i_lo  (px_data),
    .o_rgb (w_pix)
  );

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_we_n    = 1'b0;
    w_done_n  = 1'b0;
    w_ovf_n   = r_ovf;
    unique case (r_state)
      IDLE: begin
        if (cap_en)
          w_state_n = WAIT_VS;
      end
      WAIT_VS: begin
        if (w_fall) begin
          w_cnt_n   = '0;
          w_ovf_n   = 1'b0;
          w_state_n = BYTE1;
        end else if (!cap_en) begin
          w_state_n = IDLE;
        end
      end
      BYTE1: begin
        if (w_rise) begin
          w_done_n  = 1'b1;
          w_state_n = cap_en ? WAIT_VS : IDLE;
        end else if (href) begin
          w_hi_n    = px_data;
          w_state_n = BYTE2;
        end
      end
      BYTE2: begin
        // vsync rise drops a pending half pixel.
        if (w_rise) begin
          w_done_n  = 1'b1;
          w_state_n = cap_en ? WAIT_VS : IDLE;
        end else begin
          w_state_n = BYTE1;
          if (href) begin
            if (w_full) begin
              w_ovf_n = 1'b1;
            end else begin
              w_we_n   = 1'b1;
              w_addr_n = r_cnt;
              w_data_n = DW'(w_pix);
              w_cnt_n  = r_cnt + AW'(1);
            end
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_vs_q  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_vs_q  <= vsync;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_we    <= w_we_n;
      r_done  <= w_done_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign wr.addr_in  = r_addr;
  assign wr.data_in  = r_data;
  assign wr.regwrite = r_we;
  assign frame_done  = r_done;
  assign overflow    = r_ovf;

endmodule
